// File: rtl/gba_cart_reader.sv
// gba_cart_reader: GBA cartridge ROM bus initiator that streams burst halfword reads
// through a one-entry valid/ready output register.
module gba_cart_reader #(
  parameter int ADDR_SETUP = 2,
  parameter int ADDR_HOLD  = 2,
  parameter int RD_LOW     = 8,
  parameter int RD_HIGH    = 4,
  parameter int CS_HIGH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_addr,
  input  logic [15:0] cmd_len,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done,
  output logic        cart_cs_n,
  output logic        cart_rd_n,
  output logic        cart_wr_n,
  output logic [7:0]  cart_ah_out,
  output logic [15:0] cart_ad_out,
  output logic        cart_ad_oe,
  input  logic [15:0] cart_ad_in
);
  typedef enum logic [2:0] {IDLE, ADDR, LATCH, TURN, RD_LO, RD_HI, END} state_t;
  state_t state, nxt;
  logic [7:0]  cnt;
  logic [23:0] cur_addr;
  logic [15:0] remain;
  logic        take, sample;
  // Output register can accept a new word this cycle (empty or being drained).
  assign take   = !rd_valid || rd_ready;
  assign sample = state == RD_LO && cnt == 8'(RD_LOW - 1);
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = cmd_valid && cmd_len != '0 ? ADDR : IDLE;
      ADDR:    nxt = cnt == 8'(ADDR_SETUP - 1) ? LATCH : ADDR;
      LATCH:   nxt = cnt == 8'(ADDR_HOLD - 1) ? TURN : LATCH;
      TURN:    nxt = RD_LO;
      RD_LO:   nxt = sample ? RD_HI : RD_LO;
      // The cart's internal counter only spans 16 bits, so a low-half wrap forces a re-latch.
      RD_HI:   if (cnt >= 8'(RD_HIGH - 1))
                 nxt = remain == '0 || cur_addr[15:0] == '0 ? END : take ? RD_LO : RD_HI;
      // Re-latching also waits for room so the first word of the new window cannot overwrite.
      END:     if (cnt >= 8'(CS_HIGH - 1) && take) nxt = remain != '0 ? ADDR : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_addr <= '0;
      remain   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= nxt != state ? '0 : cnt == '1 ? cnt : cnt + 1'b1;
      done     <= (state == IDLE && cmd_valid && cmd_len == '0) || (state == END && nxt == IDLE);
      rd_valid <= sample || (rd_valid && !rd_ready);
      if (sample) rd_data <= cart_ad_in;
      if (state == IDLE && cmd_valid) begin
        cur_addr <= cmd_addr;
        remain   <= cmd_len;
      end else if (sample) begin
        cur_addr <= cur_addr + 1'b1;
        remain   <= remain - 1'b1;
      end
    end
  assign cmd_ready   = state == IDLE;
  assign busy        = state != IDLE;
  assign cart_cs_n   = !(state inside {LATCH, TURN, RD_LO, RD_HI});
  assign cart_rd_n   = state != RD_LO;
  assign cart_wr_n   = 1'b1;
  assign cart_ad_oe  = state inside {ADDR, LATCH};
  assign cart_ad_out = cart_ad_oe ? cur_addr[15:0] : '0;
  assign cart_ah_out = cart_ad_oe ? cur_addr[23:16] : '0;
endmodule

// File: tb/tb_gba_cart_reader.sv
// tb_gba_cart_reader: random and directed bursts against a behavioural cart and
// an expected-word queue, with protocol timing checked every cycle.
module tb_gba_cart_reader;
  localparam int ADDR_SETUP = 2, ADDR_HOLD = 2, RD_LOW = 8, RD_HIGH = 4, CS_HIGH = 4;
  logic        clk = 0, rst = 0;
  logic        cmd_valid = 0, cmd_ready, rd_valid, rd_ready = 1, busy, done;
  logic [23:0] cmd_addr = 0;
  logic [15:0] cmd_len = 0, rd_data;
  logic        cart_cs_n, cart_rd_n, cart_wr_n, cart_ad_oe;
  logic [7:0]  cart_ah_out;
  logic [15:0] cart_ad_out, cart_ad_in;
  gba_cart_reader #(.ADDR_SETUP(ADDR_SETUP), .ADDR_HOLD(ADDR_HOLD), .RD_LOW(RD_LOW),
                    .RD_HIGH(RD_HIGH), .CS_HIGH(CS_HIGH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .cart_cs_n(cart_cs_n), .cart_rd_n(cart_rd_n),
    .cart_wr_n(cart_wr_n), .cart_ah_out(cart_ah_out), .cart_ad_out(cart_ad_out),
    .cart_ad_oe(cart_ad_oe), .cart_ad_in(cart_ad_in));
  always #5 clk = ~clk;
  int checks = 0, passes = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // Cart model: latches the address when CS falls, bumps its 16-bit counter on each RD rise.
  logic [23:0] cart_a = 0;
  logic [15:0] key = 0;
  assign cart_ad_in = cart_a[15:0] ^ key;
  logic [15:0] exp_q[$], got_q[$];
  logic [23:0] lat_q[$];
  logic [23:0] base = 0;
  int rises = 0, cs_falls = 0, rd_falls = 0, exp_len = 0, exp_win = 0, pending = 0, ndone = 0;
  int rmode = 0;
  initial forever begin
    @(posedge clk);
    #1 rd_ready = rmode == 0 ? 1'b1 : rmode == 2 ? 1'b0 : $urandom_range(0, 3) != 0;
  end
  logic p_cs, p_rd, p_oe, p_valid, p_ready, p_done, first_rd;
  logic [15:0] p_data;
  int setup, hold, lo, hi, cshi;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      p_cs = 1; p_rd = 1; p_oe = 0; p_valid = 0; p_ready = 0; p_done = 0;
      setup = 0; hold = 0; lo = 0; hi = 0; cshi = 0; first_rd = 1;
    end else begin
      chk("bus_conflict", {31'b0, cart_ad_oe & ~cart_cs_n & ~cart_rd_n}, 0);
      chk("wr_n", {31'b0, cart_wr_n}, 1);
      chk("busy", {31'b0, busy}, {31'b0, !cmd_ready});
      if (p_valid && !p_ready) begin
        chk("hold_valid", {31'b0, rd_valid}, 1);
        chk("hold_data", {16'b0, rd_data}, {16'b0, p_data});
      end
      if (p_cs && !cart_cs_n) begin
        chk("latch_addr", {8'b0, cart_ah_out, cart_ad_out}, {8'b0, 24'(base + 24'(rises))});
        chk("addr_setup", {31'b0, setup >= ADDR_SETUP}, 1);
        if (cs_falls > 0) chk("cs_high_gap", {31'b0, cshi >= CS_HIGH + ADDR_SETUP}, 1);
        cart_a = {cart_ah_out, cart_ad_out};
        lat_q.push_back(cart_a);
        cs_falls++;
        first_rd = 1;
      end
      if (p_oe && !cart_ad_oe && !cart_cs_n) chk("addr_hold", hold, ADDR_HOLD);
      if (p_rd && !cart_rd_n) begin
        chk("rd_in_cs", {31'b0, cart_cs_n}, 0);
        if (!first_rd) chk("rd_high", {31'b0, hi >= RD_HIGH}, 1);
        first_rd = 0;
        rd_falls++;
      end
      if (!p_rd && cart_rd_n) begin
        chk("rd_low", lo, RD_LOW);
        cart_a[15:0] = cart_a[15:0] + 16'd1;
        rises++;
      end
      if (rd_valid && rd_ready) begin
        chk("word_expected", {31'b0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) chk("rd_data", {16'b0, rd_data}, {16'b0, exp_q.pop_front()});
        got_q.push_back(rd_data);
      end
      if (done) begin
        chk("done_pending", pending, 1);
        chk("done_pulse", {31'b0, p_done}, 0);
        chk("done_drained", exp_q.size(), 0);
        chk("done_cs_n", {31'b0, cart_cs_n}, 1);
        chk("cs_windows", cs_falls, exp_win);
        chk("rd_pulses", rd_falls, exp_len);
        pending = 0;
        ndone++;
      end
      setup = cart_cs_n && cart_ad_oe ? setup + 1 : 0;
      hold  = !cart_cs_n && cart_ad_oe ? hold + 1 : 0;
      lo    = !cart_rd_n ? lo + 1 : 0;
      hi    = cart_rd_n ? hi + 1 : 0;
      cshi  = cart_cs_n ? cshi + 1 : 0;
      p_cs = cart_cs_n; p_rd = cart_rd_n; p_oe = cart_ad_oe; p_valid = rd_valid;
      p_ready = rd_ready; p_data = rd_data; p_done = done;
    end
  end
  task automatic issue(input logic [23:0] a, input logic [15:0] n);
    @(posedge clk);
    #1;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 1);
    cmd_valid = 1; cmd_addr = a; cmd_len = n;
    base = a; rises = 0; cs_falls = 0; rd_falls = 0; exp_len = n; pending = 1;
    exp_win = n == 0 ? 0 : ((int'(a) + int'(n) - 1) >> 16) - (int'(a) >> 16) + 1;
    got_q.delete(); lat_q.delete(); exp_q.delete();
    for (int i = 0; i < int'(n); i++) exp_q.push_back(16'(int'(a) + i) ^ key);
    @(posedge clk);
    #1 cmd_valid = 0;
    chk("cmd_accepted", {31'b0, cmd_ready}, {31'b0, n == 0});
  endtask
  task automatic wait_done();
    int start = ndone;
    for (int i = 0; i < 20000 && ndone == start; i++) @(posedge clk);
    chk("done_seen", ndone - start, 1);
  endtask
  initial begin
    #1 rst = 1;
    #2;
    chk("rst_ctl", {24'b0, cart_cs_n, cart_rd_n, cart_wr_n, cart_ad_oe, rd_valid, done, busy, cmd_ready},
        32'h000000E1);
    chk("rst_ad", {cart_ah_out, cart_ad_out}, 0);
    chk("rst_data", {16'b0, rd_data}, 0);
    @(negedge clk);
    #2 rst = 0;
    key = 16'hA55A;
    issue(24'h000000, 1);
    wait_done();
    chk("t1_count", got_q.size(), 1);
    chk("t1_word", {16'b0, got_q[0]}, 32'hA55A);
    key = 0;
    issue(24'h000010, 4);
    wait_done();
    chk("t2_first", {16'b0, got_q[0]}, 32'h0010);
    chk("t2_last", {16'b0, got_q[3]}, 32'h0013);
    rmode = 2;
    issue(24'h000010, 4);
    for (int i = 0; i < 200 && !rd_valid; i++) @(negedge clk);
    chk("t3_valid", {31'b0, rd_valid}, 1);
    repeat (20) begin
      @(negedge clk);
      chk("t3_stall_rd_n", {31'b0, cart_rd_n}, 1);
      chk("t3_stall_data", {16'b0, rd_data}, 32'h0010);
    end
    rmode = 0;
    wait_done();
    chk("t3_count", got_q.size(), 4);
    chk("t3_second", {16'b0, got_q[1]}, 32'h0011);
    issue(24'h01FFFE, 4);
    wait_done();
    chk("t4_windows", lat_q.size(), 2);
    chk("t4_relatch", {8'b0, lat_q[1]}, 32'h020000);
    chk("t4_word2", {16'b0, got_q[2]}, 32'h0000);
    chk("t4_word3", {16'b0, got_q[3]}, 32'h0001);
    issue(24'h001234, 0);
    wait_done();
    chk("t5_no_cs", cs_falls, 0);
    issue(24'h000100, 8);
    for (int i = 0; i < 500 && rd_falls < 2; i++) @(posedge clk);
    chk("t6_reached_word2", rd_falls, 2);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("t6_rst_ctl", {25'b0, cart_cs_n, cart_rd_n, cart_ad_oe, rd_valid, done, busy, cmd_ready},
        32'h00000061);
    chk("t6_rst_data", {16'b0, rd_data}, 0);
    pending = 0;
    exp_q.delete();
    @(negedge clk);
    #2 rst = 0;
    issue(24'h000200, 3);
    wait_done();
    chk("t6_after", {16'b0, got_q[2]}, 32'h0202);
    rmode = 1;
    repeat (16) begin
      logic [23:0] a;
      logic [15:0] n;
      key = 16'($urandom);
      a[23:16] = 8'($urandom_range(0, 200));
      a[15:0] = $urandom_range(0, 2) == 0 ? 16'hFFFF - 16'($urandom_range(0, 6)) : 16'($urandom);
      n = 16'($urandom_range(0, 12));
      issue(a, n);
      wait_done();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
